// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller.
//  - Access size codes carried on i_mask (2'b10 is decoded as a word).
//  - MMIO FSM state encoding.
//  - gen_be(): byte-enable pattern for a given size and byte offset.
//  - DEADBEEF: load data returned when an MMIO access is aborted.
package dmem_pkg;

  localparam logic [1:0]  SZ_BYTE  = 2'b00;
  localparam logic [1:0]  SZ_HALF  = 2'b01;
  localparam logic [1:0]  SZ_WORD  = 2'b11;
  localparam logic [31:0] DEADBEEF = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } mmio_state_e;

  function automatic logic [3:0] gen_be(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane alignment shared by the SRAM and MMIO paths.
// Store side (current request):
//   i_st_off/i_st_size/i_st_data -> o_be, o_st_data (lane-replicated), o_misaligned
// Load side (offset/size captured when the access was issued):
//   i_ld_off/i_ld_size/i_ld_raw  -> o_ld_data (shifted to lane 0, upper bits zero)
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  i_st_off,
  input  logic [1:0]  i_st_size,
  input  logic [31:0] i_st_data,
  output logic [3:0]  o_be,
  output logic [31:0] o_st_data,
  output logic        o_misaligned,
  input  logic [1:0]  i_ld_off,
  input  logic [1:0]  i_ld_size,
  input  logic [31:0] i_ld_raw,
  output logic [31:0] o_ld_data
);

  logic [31:0] w_ld_shift;

  always_comb begin
    o_be         = gen_be(i_st_size, i_st_off);
    o_st_data    = i_st_data;
    o_misaligned = 1'b0;
    case (i_st_size)
      SZ_BYTE: o_st_data = {4{i_st_data[7:0]}};
      SZ_HALF: begin
        o_st_data    = {2{i_st_data[15:0]}};
        o_misaligned = i_st_off[0];
      end
      default: o_misaligned = (i_st_off != 2'b00);
    endcase
  end

  // Only the addressed lanes are returned; the core does any sign extension.
  always_comb begin
    w_ld_shift = i_ld_raw >> {i_ld_off, 3'b000};
    o_ld_data  = w_ld_shift;
    case (i_ld_size)
      SZ_BYTE: o_ld_data = {24'd0, w_ld_shift[7:0]};
      SZ_HALF: o_ld_data = {16'd0, w_ld_shift[15:0]};
      default: o_ld_data = w_ld_shift;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller between the core's EX-stage data port and WB.
// Requests below MMIO_BASE go to the tightly-coupled SRAM (1-cycle latency,
// one access per cycle); requests at or above MMIO_BASE go through a
// valid/ready MMIO FSM with a timeout. Misaligned accesses are dropped and
// acknowledged with o_misaligned the next cycle.
// Ports:
//   i_clk, i_rst                     clock, synchronous active-high reset
//   i_addr/i_wr_data/i_mask          request address, store data, size code
//   i_wr_en/i_rd_en/i_req            store, load, request strobe
//   o_rd_data/o_ack                  load data (lane 0) and completion
//   o_busy/o_misaligned/o_bus_err    FSM busy, misalign pulse, timeout pulse
//   o_sram_*/i_sram_rdata            SRAM port
//   o_mmio_*/i_mmio_*                MMIO valid/ready bus
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int          XLEN         = 32,
  parameter int          DMEM_AW      = 12,
  parameter logic [31:0] MMIO_BASE    = 32'h8000_0000,
  parameter int          MMIO_TIMEOUT = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [XLEN-1:0]    i_addr,
  input  logic [XLEN-1:0]    i_wr_data,
  input  logic [1:0]         i_mask,
  input  logic               i_wr_en,
  input  logic               i_rd_en,
  input  logic               i_req,
  output logic [XLEN-1:0]    o_rd_data,
  output logic               o_ack,
  output logic               o_busy,
  output logic               o_misaligned,
  output logic               o_bus_err,
  output logic               o_sram_en,
  output logic               o_sram_we,
  output logic [DMEM_AW-1:0] o_sram_addr,
  output logic [XLEN-1:0]    o_sram_wdata,
  output logic [3:0]         o_sram_be,
  input  logic [XLEN-1:0]    i_sram_rdata,
  output logic               o_mmio_valid,
  output logic               o_mmio_we,
  output logic [XLEN-1:0]    o_mmio_addr,
  output logic [XLEN-1:0]    o_mmio_wdata,
  output logic [3:0]         o_mmio_be,
  input  logic               i_mmio_ready,
  input  logic               i_mmio_rvalid,
  input  logic [XLEN-1:0]    i_mmio_rdata
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_REQ  = REQ;
  localparam logic [1:0] S_RESP = RESP;
  localparam int         CW     = $clog2(MMIO_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(MMIO_TIMEOUT - 1);

  logic [1:0]      r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_ack;
  logic            r_mis;
  logic            r_berr;
  logic [31:0]     r_rd_data;
  logic            r_sram_pend;
  logic [1:0]      r_ld_off;
  logic [1:0]      r_ld_size;
  logic            r_mmio_we;
  logic [31:0]     r_mmio_addr;
  logic [31:0]     r_mmio_wdata;
  logic [3:0]      r_mmio_be;

  logic            w_accept;
  logic            w_is_mmio;
  logic            w_mis;
  logic            w_sram_en;
  logic            w_mmio_launch;
  logic            w_tmo;
  logic [3:0]      w_be;
  logic [31:0]     w_st_data;
  logic [31:0]     w_ld_raw;
  logic [31:0]     w_ld_data;

  // Load source: an SRAM response is only ever pending while the FSM is
  // idle, so the two paths never need the aligner in the same cycle.
  assign w_ld_raw = r_sram_pend ? i_sram_rdata : i_mmio_rdata;

  dmem_lane_align u_align (
    .i_st_off     (i_addr[1:0]),
    .i_st_size    (i_mask),
    .i_st_data    (i_wr_data),
    .o_be         (w_be),
    .o_st_data    (w_st_data),
    .o_misaligned (w_mis),
    .i_ld_off     (r_ld_off),
    .i_ld_size    (r_ld_size),
    .i_ld_raw     (w_ld_raw),
    .o_ld_data    (w_ld_data)
  );

  assign o_busy        = (r_state != S_IDLE);
  assign w_accept      = i_req & ~o_busy & ~i_rst;
  assign w_is_mmio     = (i_addr >= MMIO_BASE);
  assign w_sram_en     = w_accept & ~w_mis & ~w_is_mmio;
  assign w_mmio_launch = w_accept & ~w_mis & w_is_mmio & (i_wr_en | i_rd_en);
  assign w_tmo         = (r_cnt == TMO_LAST);

  assign o_sram_en    = w_sram_en;
  assign o_sram_we    = w_sram_en & i_wr_en;
  assign o_sram_addr  = w_sram_en ? i_addr[DMEM_AW+1:2] : '0;
  assign o_sram_wdata = w_sram_en ? w_st_data : '0;
  assign o_sram_be    = w_sram_en ? w_be : 4'b0000;

  assign o_mmio_valid = (r_state == S_REQ);
  assign o_mmio_we    = r_mmio_we;
  assign o_mmio_addr  = r_mmio_addr;
  assign o_mmio_wdata = r_mmio_wdata;
  assign o_mmio_be    = r_mmio_be;

  // SRAM data arrives straight from the macro in the ack cycle; everything
  // else comes from the response registers.
  assign o_ack        = r_ack | r_sram_pend;
  assign o_rd_data    = r_sram_pend ? w_ld_data : r_rd_data;
  assign o_misaligned = r_mis;
  assign o_bus_err    = r_berr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_ack        <= 1'b0;
      r_mis        <= 1'b0;
      r_berr       <= 1'b0;
      r_rd_data    <= '0;
      r_sram_pend  <= 1'b0;
      r_ld_off     <= 2'b00;
      r_ld_size    <= 2'b00;
      r_mmio_we    <= 1'b0;
      r_mmio_addr  <= '0;
      r_mmio_wdata <= '0;
      r_mmio_be    <= 4'b0000;
    end else begin
      r_ack       <= 1'b0;
      r_mis       <= 1'b0;
      r_berr      <= 1'b0;
      r_rd_data   <= '0;
      r_sram_pend <= w_sram_en;

      if (w_sram_en) begin
        r_ld_off  <= i_addr[1:0];
        r_ld_size <= i_mask;
      end

      if (w_accept & w_mis) begin
        r_mis <= 1'b1;
        r_ack <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_mmio_launch) begin
            r_state      <= S_REQ;
            r_cnt        <= '0;
            r_mmio_we    <= i_wr_en;
            r_mmio_addr  <= i_addr;
            r_mmio_wdata <= w_st_data;
            r_mmio_be    <= w_be;
            r_ld_off     <= i_addr[1:0];
            r_ld_size    <= i_mask;
          end
        end
        S_REQ: begin
          r_cnt <= r_cnt + 1'b1;
          // Completion wins over a timeout landing in the same cycle.
          if (i_mmio_ready & r_mmio_we) begin
            r_state <= S_IDLE;
            r_ack   <= 1'b1;
          end else if (i_mmio_ready & i_mmio_rvalid) begin
            r_state   <= S_IDLE;
            r_ack     <= 1'b1;
            r_rd_data <= w_ld_data;
          end else if (w_tmo) begin
            r_state   <= S_IDLE;
            r_ack     <= 1'b1;
            r_berr    <= 1'b1;
            r_rd_data <= DEADBEEF;
          end else if (i_mmio_ready) begin
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_cnt <= r_cnt + 1'b1;
          if (i_mmio_rvalid) begin
            r_state   <= S_IDLE;
            r_ack     <= 1'b1;
            r_rd_data <= w_ld_data;
          end else if (w_tmo) begin
            r_state   <= S_IDLE;
            r_ack     <= 1'b1;
            r_berr    <= 1'b1;
            r_rd_data <= DEADBEEF;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed testbench for data_mem_ctrl with a small behavioural SRAM.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [1:0]  mask;
  logic        wr_en;
  logic        rd_en;
  logic        req;
  logic [31:0] rd_data;
  logic        ack;
  logic        busy;
  logic        misaligned;
  logic        bus_err;
  logic        sram_en;
  logic        sram_we;
  logic [11:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [3:0]  sram_be;
  logic [31:0] sram_rdata;
  logic        mmio_valid;
  logic        mmio_we;
  logic [31:0] mmio_addr;
  logic [31:0] mmio_wdata;
  logic [3:0]  mmio_be;
  logic        mmio_ready;
  logic        mmio_rvalid;
  logic [31:0] mmio_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:63];

  always #5 clk = ~clk;

  data_mem_ctrl dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_addr        (addr),
    .i_wr_data     (wr_data),
    .i_mask        (mask),
    .i_wr_en       (wr_en),
    .i_rd_en       (rd_en),
    .i_req         (req),
    .o_rd_data     (rd_data),
    .o_ack         (ack),
    .o_busy        (busy),
    .o_misaligned  (misaligned),
    .o_bus_err     (bus_err),
    .o_sram_en     (sram_en),
    .o_sram_we     (sram_we),
    .o_sram_addr   (sram_addr),
    .o_sram_wdata  (sram_wdata),
    .o_sram_be     (sram_be),
    .i_sram_rdata  (sram_rdata),
    .o_mmio_valid  (mmio_valid),
    .o_mmio_we     (mmio_we),
    .o_mmio_addr   (mmio_addr),
    .o_mmio_wdata  (mmio_wdata),
    .o_mmio_be     (mmio_be),
    .i_mmio_ready  (mmio_ready),
    .i_mmio_rvalid (mmio_rvalid),
    .i_mmio_rdata  (mmio_rdata)
  );

  // 1-cycle-latency SRAM with byte-enabled writes (read returns old data).
  always @(posedge clk) begin
    if (sram_en) begin
      sram_rdata <= mem[sram_addr[5:0]];
      if (sram_we)
        for (int b = 0; b < 4; b++)
          if (sram_be[b]) mem[sram_addr[5:0]][8*b +: 8] <= sram_wdata[8*b +: 8];
    end
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    mmio_ready = 1'b0; mmio_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b1; rd_en = 1'b1; wr_en = 1'b0; addr = 32'h10; mask = 2'b11;
    wr_data = '0; mmio_ready = 1'b0; mmio_rvalid = 1'b0; mmio_rdata = '0;
    tick(); tick(); #1;
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %0h want 0", ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h want 0", busy); end
    checks++; if (sram_en !== 1'b0) begin errors++; $display("FAIL reset_sram_en got %0h want 0", sram_en); end
    checks++; if (mmio_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h want 0", mmio_valid); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data got %08h want 0", rd_data); end
    checks++; if ({misaligned, bus_err} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {misaligned, bus_err}); end
    rst = 1'b0; idle_inputs();
    tick();
  endtask

  task automatic test_sram_byte();
    req = 1'b1; wr_en = 1'b1; rd_en = 1'b0; mask = 2'b00; addr = 32'h102; wr_data = 32'h0000_00A5;
    #1;
    checks++; if ({sram_en, sram_we} !== 2'b11) begin errors++; $display("FAIL sb_en_we got %b want 11", {sram_en, sram_we}); end
    checks++; if (sram_be !== 4'b0100) begin errors++; $display("FAIL sb_be got %b want 0100", sram_be); end
    checks++; if (sram_wdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL sb_wdata got %08h want A5A5A5A5", sram_wdata); end
    checks++; if (sram_addr !== 12'h040) begin errors++; $display("FAIL sb_addr got %03h want 040", sram_addr); end
    tick();
    wr_en = 1'b0; rd_en = 1'b1; wr_data = 32'h0;
    #1;
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL sb_ack got %0h want 1", ack); end
    checks++; if ({sram_en, sram_we} !== 2'b10) begin errors++; $display("FAIL lb_en_we got %b want 10", {sram_en, sram_we}); end
    tick();
    idle_inputs();
    #1;
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL lb_ack got %0h want 1", ack); end
    checks++; if (rd_data !== 32'h0000_00A5) begin errors++; $display("FAIL lb_rd_data got %08h want 000000A5", rd_data); end
    tick();
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL lb_ack_drop got %0h want 0", ack); end
  endtask

  task automatic test_sram_half_misalign();
    req = 1'b1; wr_en = 1'b1; rd_en = 1'b0; mask = 2'b11; addr = 32'h10; wr_data = 32'h1122_3344;
    #1;
    checks++; if (sram_be !== 4'b1111) begin errors++; $display("FAIL sw_be got %b want 1111", sram_be); end
    tick();
    wr_en = 1'b0; rd_en = 1'b1; mask = 2'b01; addr = 32'h12;
    #1;
    checks++; if (sram_be !== 4'b1100) begin errors++; $display("FAIL lh_be got %b want 1100", sram_be); end
    tick();
    addr = 32'h13;
    #1;
    checks++; if (rd_data !== 32'h0000_1122) begin errors++; $display("FAIL lh_rd_data got %08h want 00001122", rd_data); end
    checks++; if (sram_en !== 1'b0) begin errors++; $display("FAIL lh13_sram_en got %0h want 0", sram_en); end
    tick();
    idle_inputs();
    #1;
    checks++; if ({misaligned, ack} !== 2'b11) begin errors++; $display("FAIL mis_flags got %b want 11", {misaligned, ack}); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL mis_rd_data got %08h want 0", rd_data); end
    tick();
    checks++; if ({misaligned, ack} !== 2'b00) begin errors++; $display("FAIL mis_drop got %b want 00", {misaligned, ack}); end
  endtask

  task automatic test_mmio_write();
    req = 1'b1; wr_en = 1'b1; rd_en = 1'b0; mask = 2'b11; addr = 32'h8000_0004; wr_data = 32'h0BAD_F00D;
    #1;
    checks++; if (sram_en !== 1'b0) begin errors++; $display("FAIL mw_sram_en got %0h want 0", sram_en); end
    tick();
    req = 1'b0; wr_en = 1'b0; addr = 32'h0; wr_data = 32'h0;
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) mmio_ready = 1'b1;
      #1;
      checks++; if ({mmio_valid, mmio_we, busy} !== 3'b111) begin errors++; $display("FAIL mw_ctl_c%0d got %b want 111", k, {mmio_valid, mmio_we, busy}); end
      checks++; if (mmio_addr !== 32'h8000_0004) begin errors++; $display("FAIL mw_addr_c%0d got %08h want 80000004", k, mmio_addr); end
      checks++; if (mmio_wdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL mw_wdata_c%0d got %08h want 0BADF00D", k, mmio_wdata); end
      checks++; if (mmio_be !== 4'b1111) begin errors++; $display("FAIL mw_be_c%0d got %b want 1111", k, mmio_be); end
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL mw_early_ack_c%0d got %0h want 0", k, ack); end
      tick();
    end
    mmio_ready = 1'b0;
    #1;
    checks++; if ({mmio_valid, busy, ack} !== 3'b001) begin errors++; $display("FAIL mw_done got %b want 001", {mmio_valid, busy, ack}); end
    tick();
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL mw_ack_drop got %0h want 0", ack); end
  endtask

  task automatic test_mmio_read_fast();
    req = 1'b1; wr_en = 1'b0; rd_en = 1'b1; mask = 2'b01; addr = 32'h8000_0012;
    tick();
    req = 1'b0; rd_en = 1'b0;
    #1;
    checks++; if ({mmio_valid, mmio_we} !== 2'b10) begin errors++; $display("FAIL mr_ctl got %b want 10", {mmio_valid, mmio_we}); end
    checks++; if (mmio_be !== 4'b1100) begin errors++; $display("FAIL mr_be got %b want 1100", mmio_be); end
    checks++; if (mmio_addr !== 32'h8000_0012) begin errors++; $display("FAIL mr_addr got %08h want 80000012", mmio_addr); end
    mmio_ready = 1'b1; mmio_rvalid = 1'b1; mmio_rdata = 32'hCAFE_0000;
    tick();
    mmio_ready = 1'b0; mmio_rvalid = 1'b0; mmio_rdata = 32'h0;
    #1;
    checks++; if ({busy, mmio_valid, ack} !== 3'b001) begin errors++; $display("FAIL mr_done got %b want 001", {busy, mmio_valid, ack}); end
    checks++; if (rd_data !== 32'h0000_CAFE) begin errors++; $display("FAIL mr_rd_data got %08h want 0000CAFE", rd_data); end
    tick();
  endtask

  task automatic test_mmio_timeout();
    req = 1'b1; wr_en = 1'b0; rd_en = 1'b1; mask = 2'b11; addr = 32'h8000_0008;
    tick();
    addr = 32'h20;
    for (int k = 1; k <= 16; k++) begin
      #1;
      if (k <= 2) begin
        checks++; if (sram_en !== 1'b0) begin errors++; $display("FAIL to_sram_blocked_c%0d got %0h want 0", k, sram_en); end
      end
      checks++; if ({busy, mmio_valid, ack, bus_err} !== 4'b1100) begin errors++; $display("FAIL to_wait_c%0d got %b want 1100", k, {busy, mmio_valid, ack, bus_err}); end
      if (k == 2) idle_inputs();
      tick();
    end
    #1;
    checks++; if ({bus_err, ack} !== 2'b11) begin errors++; $display("FAIL to_err got %b want 11", {bus_err, ack}); end
    checks++; if (rd_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL to_rd_data got %08h want DEADBEEF", rd_data); end
    checks++; if ({busy, mmio_valid} !== 2'b00) begin errors++; $display("FAIL to_idle got %b want 00", {busy, mmio_valid}); end
    tick();
    checks++; if ({bus_err, ack} !== 2'b00) begin errors++; $display("FAIL to_drop got %b want 00", {bus_err, ack}); end
  endtask

  task automatic test_reset_in_resp();
    req = 1'b1; wr_en = 1'b0; rd_en = 1'b1; mask = 2'b11; addr = 32'h8000_0000;
    tick();
    req = 1'b0; rd_en = 1'b0; mmio_ready = 1'b1;
    #1;
    checks++; if (mmio_valid !== 1'b1) begin errors++; $display("FAIL rr_valid got %0h want 1", mmio_valid); end
    tick();
    mmio_ready = 1'b0;
    #1;
    checks++; if ({busy, mmio_valid} !== 2'b10) begin errors++; $display("FAIL rr_resp got %b want 10", {busy, mmio_valid}); end
    rst = 1'b1; mmio_rvalid = 1'b1; mmio_rdata = 32'h1234_5678;
    tick();
    rst = 1'b0; mmio_rvalid = 1'b0; mmio_rdata = 32'h0;
    #1;
    checks++; if ({busy, mmio_valid, ack} !== 3'b000) begin errors++; $display("FAIL rr_after got %b want 000", {busy, mmio_valid, ack}); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL rr_rd_data got %08h want 0", rd_data); end
    tick();
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rr_late_ack got %0h want 0", ack); end
    req = 1'b1; rd_en = 1'b1; mask = 2'b11; addr = 32'h10;
    #1;
    checks++; if (sram_en !== 1'b1) begin errors++; $display("FAIL rr_sram_en got %0h want 1", sram_en); end
    tick();
    idle_inputs();
    #1;
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rr_sram_ack got %0h want 1", ack); end
    checks++; if (rd_data !== 32'h1122_3344) begin errors++; $display("FAIL rr_sram_rd got %08h want 11223344", rd_data); end
    tick();
  endtask

  initial begin
    test_reset();
    test_sram_byte();
    test_sram_half_misalign();
    test_mmio_write();
    test_mmio_read_fast();
    test_mmio_timeout();
    test_reset_in_resp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
